// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and round-robin pick helper for the FIFO write arbiter
package fifo_arb_pkg;
  localparam int MAX_REQ = 8;
  typedef enum logic {IDLE, XFER} arb_state_e;
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // first set bit at or above ptr, wrapping at n-1 back to 0
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input logic [2:0] ptr, input int n);
    pick_t p;
    int k;
    p = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = (int'(ptr) + i) % n;
      if (i < n && !p.found && valid[k[2:0]]) begin
        p.found = 1'b1;
        p.idx = k[2:0];
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational rotate-and-find-first over NUM_REQ requests
module rr_priority_picker import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int IW = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               found
);
  pick_t p;
  always_comb p = rr_pick(MAX_REQ'(valid), 3'(ptr), NUM_REQ);
  assign idx = IW'(p.idx);
  assign found = p.found;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin packet-atomic arbiter for the shared FIFO write port
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST = 8,
  localparam int IW = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          forced_release
);
  localparam int BW = $clog2(MAX_BURST);
  arb_state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick_idx;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic forced_q, forced_d, pick_found, xfer, accept, rel, sel_last;
  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid(req_valid),
    .ptr  (rr_ptr_q),
    .idx  (pick_idx),
    .found(pick_found)
  );
  assign xfer = state_q == XFER;
  assign sel_last = req_last[grant_id_q];
  assign accept = xfer && req_valid[grant_id_q] && !fifo_full;
  // a last beat that is also the final allowed beat counts as a normal release
  assign rel = accept && (sel_last || beat_cnt_q == BW'(MAX_BURST - 1));
  assign req_ready = (xfer && !fifo_full) ? NUM_REQ'(1) << grant_id_q : '0;
  assign fifo_wr_en = accept;
  assign fifo_data_in = xfer ? req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_id = grant_id_q;
  assign busy = xfer;
  assign forced_release = forced_q;
  always_comb begin
    state_d = xfer ? (rel ? IDLE : XFER) : (pick_found ? XFER : IDLE);
    grant_id_d = (!xfer && pick_found) ? pick_idx : grant_id_q;
    beat_cnt_d = (!xfer || rel) ? '0 : beat_cnt_q + BW'(accept);
    rr_ptr_d = rel ? ((grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + IW'(1)) : rr_ptr_q;
    forced_d = rel && !sel_last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      beat_cnt_q <= '0;
      grant_id_q <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      grant_id_q <= grant_id_d;
      forced_q <= forced_d;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-atomic arbiter that shares the single write port of the subsystem's general-purpose FIFO among NUM_REQ requesters.
- Each requester uses a valid/ready/last stream. The arbiter locks onto one requester until that requester's last beat, or until MAX_BURST beats have been written.
- It drives the FIFO's wr_en/data_in directly and never writes while the FIFO reports full, so FIFO overflow is impossible by construction.
- Sits in the APB subsystem between peripheral producers (UART/SPI/timer event sources) and one shared FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 16, beat width; equals the FIFO width.
- MAX_BURST, 8, maximum beats per grant before forced release (≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  final beat of packet.
- req_ready  output  NUM_REQ  beat accepted when valid&ready.
- fifo_wr_en  output  1  to FIFO wr_en.
- fifo_data_in  output  DATA_WIDTH  to FIFO data_in.
- fifo_full  input  1  from FIFO full.
- grant_id  output  $clog2(NUM_REQ)  current or most recent grantee.
- busy  output  1  high in XFER.
- forced_release  output  1  one-cycle pulse when MAX_BURST ends a grant without last.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0.
  - busy=0, forced_release=0.
  - req_ready=0, fifo_wr_en=0, fifo_data_in=0.
- Reset mid-packet aborts the grant immediately. Beats already written stay in the FIFO; the arbiter does not flush them.
- FSM states: IDLE, XFER.
- IDLE:
  - req_ready all 0, fifo_wr_en=0.
  - If any req_valid: select the first set bit searching upward from rr_ptr, wrapping at NUM_REQ-1→0.
  - Register grant_id, clear beat_cnt, go to XFER.
  - No valid: stay in IDLE.
- XFER, with g=grant_id:
  - req_ready[g] = !fifo_full; every other ready bit is 0.
  - fifo_wr_en = req_valid[g] & !fifo_full.
  - fifo_data_in = req_data[g], combinational.
  - Accepted beat: beat_cnt increments.
  - Release on an accepted beat when req_last[g]=1 (normal), or when beat_cnt==MAX_BURST-1 (forced; forced_release=1 next cycle).
  - Release action: rr_ptr = g+1 mod NUM_REQ, state → IDLE.
  - req_valid[g] low mid-packet: hold XFER, no write, no timeout.
  - fifo_full high: hold XFER, ready=0, no write. Resume the first cycle full drops.
  - Last beat that is also beat MAX_BURST: normal release, forced_release=0.
- Latency:
  - One arbitration cycle. The first beat is written at the earliest in the cycle after IDLE sees valid.
  - Throughput is one beat per cycle within a grant.
  - There is one IDLE cycle between consecutive grants.
- Ordering and fairness: round-robin ensures each requester with valid asserted is granted within NUM_REQ grants.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST) bits and never wraps; release occurs first.
  - rr_ptr wraps modulo NUM_REQ. For non-power-of-2 NUM_REQ, g+1==NUM_REQ maps to 0.
- grant_id and busy are registered. req_ready and fifo_wr_en are combinational from state and inputs.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_e enum {IDLE, XFER}.
  - Function rr_pick(valid, ptr) returning index plus found flag.
  - Localparam-style helper for ID width.
- Sub-module rr_priority_picker: combinational, NUM_REQ-parameterised rotate-and-find-first. It is the natural split and is reused by other subsystem arbiters.

Test Plan:
- Single requester 1: 3-beat packet 0xA1,0xA2,0xA3 (last on beat 3) → grant_id=1; fifo_wr_en high 3 consecutive cycles starting 1 cycle after valid; data in order; busy drops the cycle after 0xA3.
- Requesters 0,2,3 valid simultaneously, 1-beat packets each, repeated → grant order 0,2,3,0,2,3; requester 1 never granted; one IDLE cycle between grants.
- fifo_full forced high for 4 cycles mid-packet on beat 2 of 5 → req_ready and fifo_wr_en low for exactly those 4 cycles; no beat lost or duplicated; 5 writes total; FIFO overflow never asserts.
- Requester 0 sends 11 beats with no last, MAX_BURST=8 → 8 writes, forced_release pulse, requester 1 (valid) granted next, then requester 0 regains the grant for the remaining 3 beats.
- Requester 2 drops valid for 3 cycles mid-packet while requester 0 is valid → grant held on 2, no writes during the gap, requester 0 waits until 2's last beat.
- rst pulsed during beat 3 of a 6-beat grant to requester 3 → next cycle state IDLE, all ready 0, grant_id=0, rr_ptr=0; with requesters 0 and 3 both valid after reset, requester 0 is granted first.
